// File: rtl/switch_pkg.sv
// Shared constants and FSM encoding for the switch output-cell schedulers.
package switch_pkg;
    localparam int NPORT      = 4;
    localparam int PTR_W      = 9;
    localparam int CELL_BEATS = 4;
    localparam int CELL_W     = 128;
    localparam int BEAT_W     = $clog2(CELL_BEATS);
    localparam int ADDR_W     = PTR_W + BEAT_W;
    localparam int PORT_W     = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_e;
endpackage

// File: rtl/switch_rr_arb4.sv
// Combinational 4-way round-robin arbiter: searches upward from rr_last+1 (mod 4).
module switch_rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] rr_last_i,
    output logic       grant_vld_o,
    output logic [3:0] grant_oh_o,
    output logic [1:0] grant_idx_o
);
    always_comb begin
        logic [1:0] idx;
        idx         = 2'd0;
        grant_vld_o = 1'b0;
        grant_oh_o  = 4'b0000;
        grant_idx_o = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = rr_last_i + 2'(i);
            if (!grant_vld_o && req_i[idx]) begin
                grant_vld_o      = 1'b1;
                grant_idx_o      = idx;
                grant_oh_o[idx]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_post_sched.sv
// Output-cell scheduler: round-robin grants queue-manager descriptors, streams cell beats
// from the cell buffer to the post stage. Optional per-port stats: SWITCH_POST_SCHED_STATS_EN.
module switch_post_sched
    import switch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       qm_req,
    input  logic [NPORT*PTR_W-1:0] qm_ptr,
    input  logic [NPORT-1:0]       qm_sof,
    input  logic [NPORT-1:0]       qm_eof,
    output logic [NPORT-1:0]       qm_ack,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [CELL_W-1:0]      mem_dout,
    output logic                   o_cell_fifo_wr,
    output logic [NPORT-1:0]       o_cell_fifo_sel,
    output logic [CELL_W-1:0]      o_cell_fifo_din,
    output logic                   o_cell_first,
    output logic                   o_cell_last,
    input  logic [NPORT-1:0]       o_cell_bp,
    output logic                   cell_free,
    output logic [PTR_W-1:0]       cell_free_ptr,
`ifdef SWITCH_POST_SCHED_STATS_EN
    input  logic [1:0]             stat_sel,
    input  logic                   stat_clr,
    output logic [31:0]            stat_cells,
`endif
    output logic                   dbg_state_o
);
    state_e              state_q, state_d;
    logic [PORT_W-1:0]   rr_last_q, rr_last_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                sof_q, sof_d;
    logic                eof_q, eof_d;
    logic [PORT_W-1:0]   port_q, port_d;

    logic                wr_q, wr_d;
    logic [NPORT-1:0]    sel_q, sel_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                free_q, free_d;
    logic [PTR_W-1:0]    free_ptr_q, free_ptr_d;

    logic [NPORT-1:0]    eligible;
    logic                grant_vld;
    logic [NPORT-1:0]    grant_oh;
    logic [PORT_W-1:0]   grant_idx;
    logic                final_beat;

    // Back-pressure only matters at arbitration; a started cell always runs to completion.
    assign eligible = qm_req & ~o_cell_bp;

    switch_rr_arb4 u_arb (
        .req_i       (eligible),
        .rr_last_i   (rr_last_q),
        .grant_vld_o (grant_vld),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx)
    );

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        beat_d    = beat_q;
        ptr_d     = ptr_q;
        sof_d     = sof_q;
        eof_d     = eof_q;
        port_d    = port_q;
        qm_ack    = '0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        case (state_q)
            ST_IDLE: begin
                // No grant while reset is held, so no descriptor is consumed and lost.
                if (grant_vld && !rst) begin
                    qm_ack    = grant_oh;
                    rr_last_d = grant_idx;
                    ptr_d     = qm_ptr[grant_idx*PTR_W +: PTR_W];
                    sof_d     = qm_sof[grant_idx];
                    eof_d     = qm_eof[grant_idx];
                    port_d    = grant_idx;
                    beat_d    = '0;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd   = 1'b1;
                mem_addr = {ptr_q, beat_q};
                beat_d   = beat_q + 1'b1;
                if (beat_q == BEAT_W'(CELL_BEATS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-side controls trail the read by one cycle, aligned with mem_dout.
    assign final_beat = mem_rd && (beat_q == BEAT_W'(CELL_BEATS - 1));

    always_comb begin
        wr_d       = mem_rd;
        sel_d      = mem_rd ? NPORT'(1 << port_q) : '0;
        first_d    = mem_rd && sof_q && (beat_q == '0);
        last_d     = final_beat && eof_q;
        free_d     = final_beat;
        free_ptr_d = final_beat ? ptr_q : free_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_last_q  <= 2'd3;
            beat_q     <= '0;
            ptr_q      <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            port_q     <= '0;
            wr_q       <= 1'b0;
            sel_q      <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            free_q     <= 1'b0;
            free_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            beat_q     <= beat_d;
            ptr_q      <= ptr_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            port_q     <= port_d;
            wr_q       <= wr_d;
            sel_q      <= sel_d;
            first_q    <= first_d;
            last_q     <= last_d;
            free_q     <= free_d;
            free_ptr_q <= free_ptr_d;
        end
    end

    assign o_cell_fifo_wr  = wr_q;
    assign o_cell_fifo_sel = sel_q;
    assign o_cell_fifo_din = wr_q ? mem_dout : '0;
    assign o_cell_first    = first_q;
    assign o_cell_last     = last_q;
    assign cell_free       = free_q;
    assign cell_free_ptr   = free_ptr_q;
    assign dbg_state_o     = state_q;

`ifdef SWITCH_POST_SCHED_STATS_EN
    logic [31:0] cnt_q [NPORT];
    logic [31:0] cnt_d [NPORT];
    logic [31:0] stat_q;

    // A cell counts on its final-beat write; clear takes precedence over that increment.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            cnt_d[p] = cnt_q[p];
            if (stat_clr) begin
                cnt_d[p] = '0;
            end else if (free_q && sel_q[p]) begin
                cnt_d[p] = cnt_q[p] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NPORT; p++) begin
                cnt_q[p] <= '0;
            end
            stat_q <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
            stat_q <= cnt_q[stat_sel];
        end
    end

    assign stat_cells = stat_q;
`endif
endmodule

// File: doc/switch_post_sched.md
Name: switch_post_sched

Overview:
- Output-cell scheduler that feeds the 4-port post stage (per-port cell data FIFOs + pointer FIFOs).
- Accepts per-port cell descriptors from the queue manager and round-robin arbitrates among ports that are requesting and not back-pressured.
- Reads each granted cell's beats from the shared cell buffer and drives the o_cell_fifo_wr/sel/din/first/last write bus.
- Returns the cell pointer to the free-pointer manager after the cell's last beat.

Parameters:
- PTR_W, 9, cell pointer width (512 cells).
- CELL_BEATS, 4, 128-bit beats per cell; must be a power of 2, ≥2.
- NPORT, 4, output ports; fixed at 4 in this revision.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- qm_req  in  4  per-port "descriptor valid".
- qm_ptr  in  4*PTR_W  per-port cell pointer; port p occupies [p*PTR_W +: PTR_W].
- qm_sof  in  4  per-port: cell is first cell of its frame.
- qm_eof  in  4  per-port: cell is last cell of its frame.
- qm_ack  out  4  one-hot, 1-cycle pulse; the descriptor is consumed.
- mem_rd  out  1  cell buffer read strobe.
- mem_addr  out  PTR_W+log2(CELL_BEATS)  {ptr, beat}.
- mem_dout  in  128  read data, valid exactly 1 cycle after mem_rd.
- o_cell_fifo_wr  out  1  post-stage write strobe.
- o_cell_fifo_sel  out  4  one-hot destination port.
- o_cell_fifo_din  out  128  cell beat data.
- o_cell_first  out  1  beat 0 of a cell with sof.
- o_cell_last  out  1  final beat of a cell with eof.
- o_cell_bp  in  4  per-port back-pressure from the post stage.
- cell_free  out  1  1-cycle pulse; pointer released.
- cell_free_ptr  out  PTR_W  pointer being released.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_last = 3, so port 0 has first priority.
- Reset asserted mid-cell: the in-flight cell is abandoned. No further writes and no cell_free pulse for it; outputs are 0 on the cycle after rst is sampled.
- FSM states: IDLE and READ.
- IDLE:
  - eligible[p] = qm_req[p] & ~o_cell_bp[p].
  - If any port is eligible, grant the first eligible port searching upward from rr_last+1 (mod 4).
  - On grant, in the same cycle: pulse qm_ack[grant]; latch ptr/sof/eof/port; set rr_last = grant; go to READ.
  - If no port is eligible, stay in IDLE with outputs idle.
- READ:
  - Issue mem_rd with beat = 0..CELL_BEATS-1 on consecutive cycles.
  - After the beat CELL_BEATS-1 read, return to IDLE.
- Timing for an ack in cycle T:
  - mem_rd is high in T+1..T+CELL_BEATS.
  - o_cell_fifo_wr is high in T+2..T+CELL_BEATS+1, with o_cell_fifo_din = mem_dout registered-through (no extra stage).
  - The next grant can occur at T+CELL_BEATS+1, giving a cell period of CELL_BEATS+1 cycles.
- o_cell_fifo_sel holds one-hot(port) on every beat. It is 0 when wr = 0; din is don't-care then.
- o_cell_first = sof & (beat 0). o_cell_last = eof & (final beat).
- cell_free pulses with the final beat's write; cell_free_ptr = latched ptr, held until the next pulse.
- Back-pressure:
  - bp is sampled only at arbitration; a cell in progress always completes.
  - The post stage asserts bp with at least CELL_BEATS+1 beats of headroom remaining.
- Descriptor stability: qm_ptr, qm_sof and qm_eof for port p must hold while qm_req[p] = 1 and no ack has been given. A requester may not drop qm_req before its ack.
- Simultaneous events:
  - All 4 ports eligible: grant sequence is 0,1,2,3,0...
  - A request rising in the same cycle the FSM enters IDLE is eligible immediately.
  - A bp rising in the same cycle as arbitration excludes that port.
- Single-cell frames (sof & eof) assert first on beat 0 and last on beat CELL_BEATS-1.

Optional Feature:
- Macro SWITCH_POST_SCHED_STATS_EN.
- Defined:
  - Adds inputs stat_sel[1:0], stat_clr and output stat_cells[31:0].
  - Per-port 32-bit counters of cells written, incremented on the final beat; they wrap at 2^32.
  - stat_cells = counter[stat_sel], registered with 1-cycle latency.
  - stat_clr synchronously zeroes all counters; if it coincides with an increment, clear wins.
  - rst zeroes the counters.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package switch_pkg: NPORT, CELL_BEATS, PTR_W, CELL_W = 128, FSM state encoding, beat counter width.
- One sub-module, switch_rr_arb4: combinational request + rr_last in, one-hot grant + grant index out. It is reused by other schedulers in the core.

Test Plan:
- Single port 0 request, ptr = 0x05A, sof = eof = 1, no bp:
  - ack at T; mem_addr = 0x168..0x16B at T+1..T+4.
  - 4 writes with sel = 4'b0001 at T+2..T+5; first at T+2; last at T+5.
  - cell_free with ptr 0x05A at T+5.
- All four ports requesting continuously, no bp: grants in order 0,1,2,3,0 at 5-cycle spacing; each ack is exactly one cycle.
- Port 1 bp = 1, ports 1 and 2 requesting: only port 2 is served. Drop bp → port 1 is granted at the next IDLE.
- bp for the active port rises at beat 1: all 4 beats are still written; that port is not regranted while bp = 1.
- 3-cell frame on port 3 (sof,-,eof): first only on cell 1 beat 0; last only on cell 3 beat 3; 3 cell_free pulses.
- rst pulsed at beat 2 of a cell: no writes and no cell_free from that cell; next grant goes to port 0 if requesting. With SWITCH_POST_SCHED_STATS_EN defined, its counter stays 0.
